// File: rtl/layer_compositor_pkg.sv
// -----------------------------------------------------------------------------
// compositor_pkg
// Shared definitions for the layer compositor:
//   - game-state encodings used to index the layer mask table
//   - fade FSM state enumeration and the full-brightness level
//   - reset contents of the mask table (MASK_INIT for the default layer count,
//     and mask_init() which builds the same table for any layer count)
// Layer roles used by the reset table (counted from the top index down):
//   n-1 credit, n-2 start, n-3 win, n-4 game over.
// -----------------------------------------------------------------------------
package compositor_pkg;

    // Requested / displayed game states.
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_WIN   = 3'd3;
    localparam logic [2:0] ST_OVER  = 3'd4;

    // Fade FSM states.
    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_IN   = 2'd2
    } fade_state_e;

    // Brightness level runs 0..FADE_MAX; FADE_MAX is identity.
    localparam int unsigned LEVEL_W  = 5;
    localparam logic [4:0]  FADE_MAX = 5'd16;

    // Reset mask table for the default ten-layer configuration.
    // Bit 10 is the background enable.
    localparam int unsigned DEF_LAYERS = 10;
    localparam logic [10:0] MASK_INIT [8] = '{
        11'h000,   // 0: unused state -> black
        11'h300,   // start: start (8) + credit (9) layers
        11'h7FF,   // play: every layer plus background
        11'h080,   // win: win layer (7)
        11'h040,   // game over: game-over layer (6)
        11'h000,
        11'h000,
        11'h000
    };

    // Reset mask entry for an arbitrary layer count n (4 <= n <= 30).
    // Produces the same values as MASK_INIT when n == DEF_LAYERS.
    function automatic logic [31:0] mask_init(input int unsigned n, input logic [2:0] st);
        logic [31:0] m;
        m = 32'd0;
        case (st)
            ST_START: m = (32'd1 << (n - 32'd2)) | (32'd1 << (n - 32'd1));
            ST_PLAY:  m = (32'd1 << (n + 32'd1)) - 32'd1;
            ST_WIN:   m = 32'd1 << (n - 32'd3);
            ST_OVER:  m = 32'd1 << (n - 32'd4);
            default:  m = 32'd0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/layer_compositor_fade_scaler.sv
// -----------------------------------------------------------------------------
// fade_scaler
// Scales one colour channel by a brightness level: o = (c * level) >> 4.
// The product is formed at full width before the shift so no precision is
// lost; level 16 returns the input unchanged, level 0 returns black.
// Ports:
//   i_color  COLOR_BITS  channel value
//   i_level  LEVEL_W     brightness 0..16
//   o_color  COLOR_BITS  scaled channel value (combinational)
// -----------------------------------------------------------------------------
module fade_scaler
    import compositor_pkg::*;
#(
    parameter int COLOR_BITS = 4
) (
    input  logic [COLOR_BITS-1:0] i_color,
    input  logic [LEVEL_W-1:0]    i_level,
    output logic [COLOR_BITS-1:0] o_color
);

    localparam int PROD_W = COLOR_BITS + LEVEL_W;

    logic [PROD_W-1:0] w_product;

    assign w_product = PROD_W'(i_color) * PROD_W'(i_level);
    // Result never exceeds the input, so the truncation drops only zeros.
    assign o_color   = COLOR_BITS'(w_product >> 3'd4);

endmodule

// File: rtl/layer_compositor.sv
// -----------------------------------------------------------------------------
// layer_compositor
// Priority compositor for sprite/screen layers with a per-game-state layer
// mask table and a frame-paced fade-out / fade-in engine.
//
// Pixel path (2-cycle latency, no stalls):
//   stage 1: mask the draw requests, pick the lowest-index active layer
//            (or background / black), register RGB + index
//   stage 2: scale RGB by the current brightness level, register RGB + index
//
// Ports:
//   i_clk          system clock (rising edge)
//   i_reset        synchronous active-high reset
//   i_game_state   requested game state
//   i_frame_start  one-cycle pulse per video frame
//   i_layer_dr     per-layer draw request
//   i_layer_rgb    packed RGB per layer, layer i in slice i, R in high bits
//   i_bg_rgb       background colour
//   i_mask_wr      mask-table write strobe
//   i_mask_addr    mask-table entry to write
//   i_mask_data    new mask, top bit enables the background
//   o_red/green/blue  registered pixel colour
//   o_hit_layer    winning layer index, NUM_LAYERS for background/black
//   o_fading       high while the fade FSM is not idle
// -----------------------------------------------------------------------------
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 10,
    parameter int COLOR_BITS = 4,
    parameter int FADE_EN    = 1
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic [2:0]                         i_game_state,
    input  logic                               i_frame_start,
    input  logic [NUM_LAYERS-1:0]              i_layer_dr,
    input  logic [NUM_LAYERS*3*COLOR_BITS-1:0] i_layer_rgb,
    input  logic [3*COLOR_BITS-1:0]            i_bg_rgb,
    input  logic                               i_mask_wr,
    input  logic [2:0]                         i_mask_addr,
    input  logic [NUM_LAYERS:0]                i_mask_data,
    output logic [COLOR_BITS-1:0]              o_red,
    output logic [COLOR_BITS-1:0]              o_green,
    output logic [COLOR_BITS-1:0]              o_blue,
    output logic [$clog2(NUM_LAYERS+1)-1:0]    o_hit_layer,
    output logic                               o_fading
);

    localparam int IDX_W  = $clog2(NUM_LAYERS + 1);
    localparam int RGB_W  = 3 * COLOR_BITS;
    localparam int MASK_W = NUM_LAYERS + 1;
    localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(NUM_LAYERS);

    // Mask table and fade engine state.
    logic [MASK_W-1:0]  r_mask [8];
    logic [2:0]         r_disp_state;
    logic [LEVEL_W-1:0] r_level;
    fade_state_e        r_fade_state;
    logic               r_fading;

    fade_state_e        w_next_state;
    logic [LEVEL_W-1:0] w_next_level;
    logic [2:0]         w_next_disp;

    // Layer selection.
    logic [MASK_W-1:0]     w_cur_mask;
    logic [NUM_LAYERS-1:0] w_active;
    logic [NUM_LAYERS-1:0] w_onehot;
    logic [RGB_W-1:0]      w_sel_rgb;
    logic [IDX_W-1:0]      w_sel_idx;

    // Pipeline.
    logic [RGB_W-1:0] r_s1_rgb;
    logic [IDX_W-1:0] r_s1_idx;
    logic [RGB_W-1:0] w_scaled_rgb;
    logic [RGB_W-1:0] r_s2_rgb;
    logic [IDX_W-1:0] r_s2_idx;

    // The table is indexed by the displayed state, so a requested state only
    // changes the visible layers once the fade has reached black.
    assign w_cur_mask = r_mask[r_disp_state];
    assign w_active   = i_layer_dr & w_cur_mask[NUM_LAYERS-1:0];
    // Isolate the lowest set bit: that layer has the highest priority.
    assign w_onehot   = w_active & (~w_active + NUM_LAYERS'(1));

    // Priority select of the winning layer, background or black.
    always_comb begin
        w_sel_rgb = {RGB_W{1'b0}};
        w_sel_idx = IDX_NONE;
        if (w_active == {NUM_LAYERS{1'b0}}) begin
            if (w_cur_mask[NUM_LAYERS]) begin
                w_sel_rgb = i_bg_rgb;
            end else begin
                w_sel_rgb = {RGB_W{1'b0}};
            end
        end else begin
            w_sel_idx = {IDX_W{1'b0}};
            for (int i = 0; i < NUM_LAYERS; i++) begin
                w_sel_rgb = w_sel_rgb |
                    (w_onehot[i] ? i_layer_rgb[i*RGB_W +: RGB_W] : {RGB_W{1'b0}});
                w_sel_idx = w_sel_idx |
                    (w_onehot[i] ? IDX_W'(i) : {IDX_W{1'b0}});
            end
        end
    end

    // Fade FSM next-state, next-level and displayed-state latch.
    always_comb begin
        w_next_state = r_fade_state;
        w_next_level = r_level;
        w_next_disp  = r_disp_state;
        if (FADE_EN == 0) begin
            w_next_state = FADE_IDLE;
            w_next_level = FADE_MAX;
            w_next_disp  = i_game_state;
        end else begin
            case (r_fade_state)
                FADE_IDLE: begin
                    // frame_start is ignored here, so a pulse coinciding
                    // with the start of a fade does not consume a step.
                    if (i_game_state != r_disp_state) begin
                        w_next_state = FADE_OUT;
                    end else begin
                        w_next_state = FADE_IDLE;
                    end
                end
                FADE_OUT: begin
                    // Requested-state changes are deliberately not looked at
                    // until black is reached; the latest request is latched.
                    if (i_frame_start) begin
                        if (r_level != 5'd0) begin
                            w_next_level = r_level - 5'd1;
                        end else begin
                            w_next_disp  = i_game_state;
                            w_next_state = FADE_IN;
                        end
                    end else begin
                        w_next_state = FADE_OUT;
                    end
                end
                FADE_IN: begin
                    // A new request while brightening reverses from the
                    // current level instead of jumping.
                    if (i_game_state != r_disp_state) begin
                        w_next_state = FADE_OUT;
                    end else if (i_frame_start) begin
                        if (r_level < FADE_MAX) begin
                            w_next_level = r_level + 5'd1;
                        end else begin
                            w_next_state = FADE_IDLE;
                        end
                    end else begin
                        w_next_state = FADE_IN;
                    end
                end
                default: begin
                    // Illegal encoding: recover by fading in from black.
                    w_next_state = FADE_OUT;
                    w_next_level = 5'd0;
                end
            endcase
        end
    end

    // Fade FSM registers; after reset the first frame_start latches the
    // requested state and starts a fade-in from black.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fade_state <= (FADE_EN != 0) ? FADE_OUT : FADE_IDLE;
            r_level      <= (FADE_EN != 0) ? 5'd0 : FADE_MAX;
            r_disp_state <= 3'd0;
            r_fading     <= (FADE_EN != 0);
        end else begin
            r_fade_state <= w_next_state;
            r_level      <= w_next_level;
            r_disp_state <= w_next_disp;
            r_fading     <= (w_next_state != FADE_IDLE);
        end
    end

    // Mask table: reset contents and single-entry writes. A lookup in the
    // write cycle sees the old entry because the table is read from flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int e = 0; e < 8; e++) begin
                r_mask[e] <= MASK_W'(mask_init(NUM_LAYERS, 3'(e)));
            end
        end else if (i_mask_wr) begin
            r_mask[i_mask_addr] <= i_mask_data;
        end
    end

    // Per-channel brightness scaling of the stage-1 pixel.
    fade_scaler #(.COLOR_BITS(COLOR_BITS)) u_scale_r (
        .i_color (r_s1_rgb[3*COLOR_BITS-1:2*COLOR_BITS]),
        .i_level (r_level),
        .o_color (w_scaled_rgb[3*COLOR_BITS-1:2*COLOR_BITS])
    );

    fade_scaler #(.COLOR_BITS(COLOR_BITS)) u_scale_g (
        .i_color (r_s1_rgb[2*COLOR_BITS-1:COLOR_BITS]),
        .i_level (r_level),
        .o_color (w_scaled_rgb[2*COLOR_BITS-1:COLOR_BITS])
    );

    fade_scaler #(.COLOR_BITS(COLOR_BITS)) u_scale_b (
        .i_color (r_s1_rgb[COLOR_BITS-1:0]),
        .i_level (r_level),
        .o_color (w_scaled_rgb[COLOR_BITS-1:0])
    );

    // Two-stage pixel pipeline: select, then scale.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1_rgb <= {RGB_W{1'b0}};
            r_s1_idx <= IDX_NONE;
            r_s2_rgb <= {RGB_W{1'b0}};
            r_s2_idx <= IDX_NONE;
        end else begin
            r_s1_rgb <= w_sel_rgb;
            r_s1_idx <= w_sel_idx;
            r_s2_rgb <= w_scaled_rgb;
            r_s2_idx <= r_s1_idx;
        end
    end

    assign o_red       = r_s2_rgb[3*COLOR_BITS-1:2*COLOR_BITS];
    assign o_green     = r_s2_rgb[2*COLOR_BITS-1:COLOR_BITS];
    assign o_blue      = r_s2_rgb[COLOR_BITS-1:0];
    assign o_hit_layer = r_s2_idx;
    assign o_fading    = r_fading;

endmodule

// File: tb/tb_layer_compositor.sv
// -----------------------------------------------------------------------------
// tb_layer_compositor
// Directed bench for layer_compositor. Two instances share all inputs:
// u_fade (fade engine enabled) and u_nofade (fade engine disabled).
// -----------------------------------------------------------------------------
module tb_layer_compositor;
    import compositor_pkg::*;

    logic         clk;
    logic         reset;
    logic [2:0]   game_state;
    logic         frame_start;
    logic [9:0]   layer_dr;
    logic [119:0] layer_rgb;
    logic [11:0]  bg_rgb;
    logic         mask_wr;
    logic [2:0]   mask_addr;
    logic [10:0]  mask_data;

    logic [3:0] a_red, a_green, a_blue, a_hit;
    logic       a_fading;
    logic [3:0] b_red, b_green, b_blue, b_hit;
    logic       b_fading;
    logic [11:0] a_rgb, b_rgb;

    int n_assert = 0;
    int n_fail   = 0;

    assign a_rgb = {a_red, a_green, a_blue};
    assign b_rgb = {b_red, b_green, b_blue};

    layer_compositor #(.NUM_LAYERS(10), .COLOR_BITS(4), .FADE_EN(1)) u_fade (
        .i_clk(clk), .i_reset(reset), .i_game_state(game_state),
        .i_frame_start(frame_start), .i_layer_dr(layer_dr), .i_layer_rgb(layer_rgb),
        .i_bg_rgb(bg_rgb), .i_mask_wr(mask_wr), .i_mask_addr(mask_addr),
        .i_mask_data(mask_data), .o_red(a_red), .o_green(a_green), .o_blue(a_blue),
        .o_hit_layer(a_hit), .o_fading(a_fading)
    );

    layer_compositor #(.NUM_LAYERS(10), .COLOR_BITS(4), .FADE_EN(0)) u_nofade (
        .i_clk(clk), .i_reset(reset), .i_game_state(game_state),
        .i_frame_start(frame_start), .i_layer_dr(layer_dr), .i_layer_rgb(layer_rgb),
        .i_bg_rgb(bg_rgb), .i_mask_wr(mask_wr), .i_mask_addr(mask_addr),
        .i_mask_data(mask_data), .o_red(b_red), .o_green(b_green), .o_blue(b_blue),
        .o_hit_layer(b_hit), .o_fading(b_fading)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        tick(1);
    endtask

    task automatic set_layer(input int idx, input logic [11:0] rgb);
        layer_rgb[idx*12 +: 12] = rgb;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; game_state = 3'd2; frame_start = 1'b0;
        layer_dr = 10'd0; layer_rgb = 120'd0; bg_rgb = 12'h123;
        mask_wr = 1'b0; mask_addr = 3'd0; mask_data = 11'd0;
        tick(2);

        // Reset state.
        chk("rst_a_rgb",    32'(a_rgb), 32'h000);
        chk("rst_a_hit",    32'(a_hit), 32'd10);
        chk("rst_a_fading", 32'(a_fading), 32'd1);
        chk("rst_a_level",  32'(u_fade.r_level), 32'd0);
        chk("rst_a_state",  32'(u_fade.r_fade_state), 32'(FADE_OUT));
        chk("rst_b_hit",    32'(b_hit), 32'd10);
        chk("rst_b_level",  32'(u_nofade.r_level), 32'd16);

        // Play state, no draw requests -> background on the no-fade unit.
        reset = 1'b0;
        tick(3);
        chk("bg_b_rgb",    32'(b_rgb), 32'h123);
        chk("bg_b_hit",    32'(b_hit), 32'd10);
        chk("bg_b_fading", 32'(b_fading), 32'd0);
        chk("bg_a_rgb",    32'(a_rgb), 32'h000);

        // Layers 1 and 2 requested: layer 1 wins, two cycles later.
        layer_dr = 10'b0000000110;
        set_layer(1, 12'hF00);
        set_layer(2, 12'h0F0);
        tick(1);
        chk("lat1_b_rgb", 32'(b_rgb), 32'h123);
        tick(1);
        chk("lat2_b_rgb", 32'(b_rgb), 32'hF00);
        chk("lat2_b_hit", 32'(b_hit), 32'd1);

        // All layers requested: layer 0 wins.
        layer_dr = 10'h3FF;
        set_layer(0, 12'h5A5);
        tick(2);
        chk("all_b_rgb", 32'(b_rgb), 32'h5A5);
        chk("all_b_hit", 32'(b_hit), 32'd0);

        // Only the top layer requested.
        layer_dr = 10'h200;
        set_layer(9, 12'hABC);
        tick(2);
        chk("top_b_rgb", 32'(b_rgb), 32'hABC);
        chk("top_b_hit", 32'(b_hit), 32'd9);

        // Clear the play background enable; old entry used in the write cycle.
        layer_dr = 10'd0;
        tick(2);
        mask_wr = 1'b1; mask_addr = 3'd2; mask_data = 11'h3FF;
        tick(1);
        mask_wr = 1'b0;
        tick(1);
        chk("mwr1_b_rgb", 32'(b_rgb), 32'h123);
        tick(1);
        chk("mwr2_b_rgb", 32'(b_rgb), 32'h000);
        chk("mwr2_b_hit", 32'(b_hit), 32'd10);

        // Entry 7 is writable and used by game_state 7.
        mask_wr = 1'b1; mask_addr = 3'd7; mask_data = 11'h001;
        game_state = 3'd7; layer_dr = 10'h001;
        tick(1);
        mask_wr = 1'b0;
        tick(2);
        chk("e7_b_rgb", 32'(b_rgb), 32'h5A5);
        chk("e7_b_hit", 32'(b_hit), 32'd0);

        // game_state 5 uses its default all-zero entry -> black.
        game_state = 3'd5;
        tick(3);
        chk("e5_b_rgb", 32'(b_rgb), 32'h000);
        chk("e5_b_hit", 32'(b_hit), 32'd10);

        // Reset, then fade into the start screen.
        reset = 1'b1; game_state = 3'd1; layer_dr = 10'h100;
        set_layer(8, 12'h888);
        tick(1);
        reset = 1'b0;
        pulse();
        chk("latch_state", 32'(u_fade.r_fade_state), 32'(FADE_IN));
        chk("latch_level", 32'(u_fade.r_level), 32'd0);
        chk("latch_disp",  32'(u_fade.r_disp_state), 32'd1);
        repeat (8) pulse();
        chk("in8_level", 32'(u_fade.r_level), 32'd8);
        chk("in8_a_rgb", 32'(a_rgb), 32'h444);
        chk("in8_a_hit", 32'(a_hit), 32'd8);
        repeat (8) pulse();
        chk("in16_level",  32'(u_fade.r_level), 32'd16);
        chk("in16_fading", 32'(a_fading), 32'd1);
        chk("in16_a_rgb",  32'(a_rgb), 32'h888);
        pulse();
        chk("idle_fading", 32'(a_fading), 32'd0);
        chk("idle_state",  32'(u_fade.r_fade_state), 32'(FADE_IDLE));

        // Move to play: 16 down, latch, 16 up, exit.
        game_state = 3'd2;
        tick(1);
        repeat (34) pulse();
        chk("play_state", 32'(u_fade.r_fade_state), 32'(FADE_IDLE));
        chk("play_disp",  32'(u_fade.r_disp_state), 32'd2);
        chk("play_a_rgb", 32'(a_rgb), 32'h888);

        // Play -> game over; coincident frame_start must not decrement.
        game_state = 3'd4; frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        chk("go_state", 32'(u_fade.r_fade_state), 32'(FADE_OUT));
        chk("go_level", 32'(u_fade.r_level), 32'd16);
        repeat (8) pulse();
        chk("out8_level", 32'(u_fade.r_level), 32'd8);

        // Requests during fade-out are ignored.
        game_state = 3'd3;
        tick(2);
        chk("ign_state", 32'(u_fade.r_fade_state), 32'(FADE_OUT));
        chk("ign_level", 32'(u_fade.r_level), 32'd8);
        chk("ign_disp",  32'(u_fade.r_disp_state), 32'd2);
        game_state = 3'd4;
        repeat (8) pulse();
        chk("out0_level", 32'(u_fade.r_level), 32'd0);
        chk("out0_a_rgb", 32'(a_rgb), 32'h000);
        chk("out0_a_hit", 32'(a_hit), 32'd8);
        pulse();
        chk("go_disp",     32'(u_fade.r_disp_state), 32'd4);
        chk("go_in_state", 32'(u_fade.r_fade_state), 32'(FADE_IN));
        repeat (10) pulse();
        chk("in10_level", 32'(u_fade.r_level), 32'd10);

        // Change during fade-in reverses from the current level.
        game_state = 3'd2;
        tick(1);
        chk("rev_state", 32'(u_fade.r_fade_state), 32'(FADE_OUT));
        chk("rev_level", 32'(u_fade.r_level), 32'd10);
        repeat (5) pulse();
        chk("rev5_level", 32'(u_fade.r_level), 32'd5);

        // Reset mid-fade abandons it immediately.
        reset = 1'b1;
        tick(1);
        chk("mid_a_rgb",   32'(a_rgb), 32'h000);
        chk("mid_a_hit",   32'(a_hit), 32'd10);
        chk("mid_level",   32'(u_fade.r_level), 32'd0);
        chk("mid_state",   32'(u_fade.r_fade_state), 32'(FADE_OUT));
        chk("mid_disp",    32'(u_fade.r_disp_state), 32'd0);
        chk("mid_b_level", 32'(u_nofade.r_level), 32'd16);
        chk("mid_b_state", 32'(u_nofade.r_fade_state), 32'(FADE_IDLE));
        reset = 1'b0;
        tick(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
